// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module : core_pkg
//  Shared encodings for the writeback path: result-select and load-type codes.
//  Revision: 1.0
// ============================================================================
package core_pkg;

  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_LOAD = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_IMM  = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic is_half_load(input logic [2:0] f3);
    return (f3 == F3_LH) || (f3 == F3_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module : load_extend
//  Picks the addressed byte/half out of a memory word and sign/zero extends it.
//  Revision: 1.0
// ============================================================================
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o,
  output logic            misaligned_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = word_i[{off_i, 3'b000} +: 8];
    half_w = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_w[7]}}, byte_w};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_w};
      F3_LH:   data_o = {{(XLEN-16){half_w[15]}}, half_w};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_w};
      default: data_o = word_i;
    endcase

    misaligned_o = (is_half_load(funct3_i) && off_i[0]) ||
                   ((funct3_i == F3_LW) && (off_i != 2'b00));
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module : mem_wb_stage
//  MEM/WB pipeline register, writeback mux, x0/misalign write gating, instret.
//  Revision: 1.0
// ============================================================================
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallW,
  input  logic             flushW,
  input  logic             validM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       funct3M,
  input  logic [RA_W-1:0]  RdM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ReadDataM,
  input  logic [XLEN-1:0]  PC_plus4M,
  input  logic [XLEN-1:0]  ImmExtM,
  output logic [RA_W-1:0]  A3,
  output logic [XLEN-1:0]  WD3,
  output logic             WE3,
  output logic             RegWriteW,
  output logic             misalignedW,
  output logic [CNT_W-1:0] instret
);

  logic            valid_q;
  logic            regwrite_q;
  logic [1:0]      src_q;
  logic [2:0]      funct3_q;
  logic [RA_W-1:0] rd_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] imm_q;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  logic [XLEN-1:0] load_data_w;
  logic            load_mis_w;
  logic            is_load_w;

  // Stall outranks flush so a held instruction is never lost to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else if (!stallW) begin
      if (flushW) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
        src_q      <= '0;
        funct3_q   <= '0;
        rd_q       <= '0;
        alu_q      <= '0;
        rdata_q    <= '0;
        pc4_q      <= '0;
        imm_q      <= '0;
      end else begin
        valid_q    <= validM;
        regwrite_q <= RegWriteM;
        src_q      <= ResultSrcM;
        funct3_q   <= funct3M;
        rd_q       <= RdM;
        alu_q      <= ALUResultM;
        rdata_q    <= ReadDataM;
        pc4_q      <= PC_plus4M;
        imm_q      <= ImmExtM;
      end
    end
  end

  // An instruction retires on the edge it leaves WB, regardless of flush.
  always_comb begin
    instret_d = instret_q;
    if (valid_q && !stallW) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word_i       (rdata_q),
    .off_i        (alu_q[1:0]),
    .funct3_i     (funct3_q),
    .data_o       (load_data_w),
    .misaligned_o (load_mis_w)
  );

  always_comb begin
    is_load_w = (result_src_e'(src_q) == RESULT_LOAD);

    case (result_src_e'(src_q))
      RESULT_LOAD: WD3 = load_data_w;
      RESULT_PC4:  WD3 = pc4_q;
      RESULT_IMM:  WD3 = imm_q;
      default:     WD3 = alu_q;
    endcase

    misalignedW = valid_q && is_load_w && load_mis_w;
    WE3         = valid_q && regwrite_q && (rd_q != '0) && !misalignedW;
  end

  assign A3        = rd_q;
  assign RegWriteW = WE3;
  assign instret   = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module : tb_mem_wb_stage
//  Self-checking bench for mem_wb_stage against a behavioural writeback model.
//  Revision: 1.0
// ============================================================================
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallW = 1'b0, flushW = 1'b0, validM = 1'b0, RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = '0;
  logic [2:0]  funct3M = '0;
  logic [4:0]  RdM = '0;
  logic [31:0] ALUResultM = '0, ReadDataM = '0, PC_plus4M = '0, ImmExtM = '0;

  logic [4:0]  A3, A3_s;
  logic [31:0] WD3, WD3_s;
  logic        WE3, WE3_s, RegWriteW, RegWriteW_s, misalignedW, misalignedW_s;
  logic [63:0] instret;
  logic [3:0]  instret_s;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stallW(stallW), .flushW(flushW), .validM(validM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PC_plus4M(PC_plus4M), .ImmExtM(ImmExtM),
    .A3(A3), .WD3(WD3), .WE3(WE3), .RegWriteW(RegWriteW), .misalignedW(misalignedW),
    .instret(instret)
  );

  // Narrow counter instance so the wrap-around can be reached quickly.
  mem_wb_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .stallW(stallW), .flushW(flushW), .validM(validM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PC_plus4M(PC_plus4M), .ImmExtM(ImmExtM),
    .A3(A3_s), .WD3(WD3_s), .WE3(WE3_s), .RegWriteW(RegWriteW_s), .misalignedW(misalignedW_s),
    .instret(instret_s)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: what the instruction in WB looks like, plus retired count.
  logic        m_valid, m_rw;
  logic [1:0]  m_src;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdata, m_pc4, m_imm;
  logic [63:0] m_cnt;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (f3)
      3'd0: return {{24{sh[7]}}, sh[7:0]};
      3'd4: return {24'h0, sh[7:0]};
      3'd1: begin sh = w >> (16 * off[1]); return {{16{sh[15]}}, sh[15:0]}; end
      3'd5: begin sh = w >> (16 * off[1]); return {16'h0, sh[15:0]}; end
      default: return w;
    endcase
  endfunction

  // {A3, WD3, WE3, RegWriteW, misalignedW}
  function automatic logic [39:0] exp_out();
    logic mis, we;
    logic [31:0] wd;
    mis = m_valid && (m_src == 2'd1) &&
          (((m_f3 == 3'd1 || m_f3 == 3'd5) && m_alu[0]) || (m_f3 == 3'd2 && m_alu[1:0] != 2'd0));
    we  = m_valid && m_rw && (m_rd != 5'd0) && !mis;
    case (m_src)
      2'd0: wd = m_alu;
      2'd1: wd = ref_load(m_rdata, m_alu[1:0], m_f3);
      2'd2: wd = m_pc4;
      default: wd = m_imm;
    endcase
    return {m_rd, wd, we, we, mis};
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_src = 0; m_f3 = 0; m_rd = 0;
    m_alu = 0; m_rdata = 0; m_pc4 = 0; m_imm = 0;
  endtask

  // Advance the model with the currently applied inputs, then clock the DUT.
  task automatic tick();
    if (!rst_n) begin
      model_clear();
      m_cnt = 0;
    end else begin
      if (m_valid && !stallW) m_cnt = m_cnt + 1;
      if (!stallW) begin
        if (flushW) model_clear();
        else begin
          m_valid = validM; m_rw = RegWriteM; m_src = ResultSrcM; m_f3 = funct3M;
          m_rd = RdM; m_alu = ALUResultM; m_rdata = ReadDataM; m_pc4 = PC_plus4M;
          m_imm = ImmExtM;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4, input logic [31:0] imm);
    validM = v; RegWriteM = rw; ResultSrcM = src; funct3M = f3; RdM = rd;
    ALUResultM = alu; ReadDataM = rdata; PC_plus4M = pc4; ImmExtM = imm;
  endtask

  task automatic test_reset();
    model_clear();
    m_cnt = 0;
    rst_n = 0;
    tick();
    tick();
    checks++;
    if ({A3, WD3, WE3, RegWriteW, misalignedW} !== 40'h0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0", {A3, WD3, WE3, RegWriteW, misalignedW});
    end
    checks++;
    if (instret !== 64'h0 || instret_s !== 4'h0) begin
      errors++; $display("FAIL reset_instret: got %0d/%0d exp 0", instret, instret_s);
    end
    rst_n = 1;
  endtask

  task automatic test_alu();
    drive(1, 1, 2'b00, 3'd0, 5'd5, 32'h1234, 32'hDEAD_BEEF, 32'h104, 32'h5000);
    tick();
    checks++;
    if ({A3, WD3, WE3, RegWriteW} !== {5'd5, 32'h1234, 1'b1, 1'b1}) begin
      errors++; $display("FAIL alu_wb: got A3=%0d WD3=%h WE3=%b exp A3=5 WD3=1234 WE3=1", A3, WD3, WE3);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (instret !== 64'd1) begin
      errors++; $display("FAIL alu_retire: got %0d exp 1", instret);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [1:0]  offs[4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [31:0] exps[4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2'b01, f3s[i], 5'd7, {30'h400, offs[i]}, 32'h80FF_7F01, 0, 0);
      tick();
      checks++;
      if (WD3 !== exps[i] || WE3 !== 1'b1 || misalignedW !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: got WD3=%h WE3=%b mis=%b exp WD3=%h WE3=1 mis=0",
                 i, WD3, WE3, misalignedW, exps[i]);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_x0_misaligned();
    logic [63:0] c0;
    drive(1, 1, 2'b00, 3'd0, 5'd0, 32'h55, 0, 0, 0);
    tick();
    checks++;
    if (WE3 !== 1'b0 || WD3 !== 32'h55) begin
      errors++; $display("FAIL x0_gate: got WE3=%b WD3=%h exp WE3=0 WD3=55", WE3, WD3);
    end
    drive(1, 1, 2'b01, 3'd2, 5'd3, 32'h1002, 32'h1122_3344, 0, 0);
    tick();
    c0 = m_cnt;
    checks++;
    if (misalignedW !== 1'b1 || WE3 !== 1'b0 || RegWriteW !== 1'b0) begin
      errors++; $display("FAIL lw_misaligned: got mis=%b WE3=%b exp mis=1 WE3=0", misalignedW, WE3);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (instret !== c0 + 64'd1) begin
      errors++; $display("FAIL misaligned_retire: got %0d exp %0d", instret, c0 + 64'd1);
    end
  endtask

  task automatic test_stall_flush();
    logic [63:0] c0;
    drive(1, 1, 2'b11, 3'd0, 5'd9, 32'h0, 0, 0, 32'hABCD_0000);
    tick();
    c0 = m_cnt;
    drive(1, 1, 2'b00, 3'd0, 5'd10, 32'h7777, 0, 0, 0);
    stallW = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (A3 !== 5'd9 || WD3 !== 32'hABCD_0000 || WE3 !== 1'b1 || instret !== c0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got A3=%0d WD3=%h WE3=%b cnt=%0d exp A3=9 WD3=abcd0000 WE3=1 cnt=%0d",
                 i, A3, WD3, WE3, instret, c0);
      end
    end
    stallW = 0;
    tick();
    checks++;
    if (A3 !== 5'd10 || WD3 !== 32'h7777 || instret !== c0 + 64'd1) begin
      errors++; $display("FAIL stall_release: got A3=%0d WD3=%h cnt=%0d exp 10/7777/%0d",
                         A3, WD3, instret, c0 + 64'd1);
    end
    flushW = 1;
    tick();
    checks++;
    if (WE3 !== 1'b0 || A3 !== 5'd0 || instret !== c0 + 64'd2) begin
      errors++; $display("FAIL flush_bubble: got WE3=%b A3=%0d cnt=%0d exp 0/0/%0d",
                         WE3, A3, instret, c0 + 64'd2);
    end
    tick();
    checks++;
    if (instret !== c0 + 64'd2) begin
      errors++; $display("FAIL flush_flat: got %0d exp %0d", instret, c0 + 64'd2);
    end
    flushW = 0;
    drive(1, 1, 2'b10, 3'd0, 5'd12, 0, 0, 32'h2004, 0);
    tick();
    stallW = 1; flushW = 1;
    tick();
    checks++;
    if (A3 !== 5'd12 || WD3 !== 32'h2004 || WE3 !== 1'b1) begin
      errors++; $display("FAIL stall_over_flush: got A3=%0d WD3=%h WE3=%b exp 12/2004/1", A3, WD3, WE3);
    end
    stallW = 0; flushW = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    logic [2:0] f3tab[7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            f3tab[$urandom_range(0, 6)], 5'($urandom_range(0, 31)), $urandom, $urandom,
            $urandom, $urandom);
      stallW = ($urandom_range(0, 4) == 0);
      flushW = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if ({A3, WD3, WE3, RegWriteW, misalignedW} !== exp_out() || instret !== m_cnt) begin
        errors++;
        $display("FAIL random_%0d: got %h cnt=%0d exp %h cnt=%0d",
                 i, {A3, WD3, WE3, RegWriteW, misalignedW}, instret, exp_out(), m_cnt);
      end
      checks++;
      if ({A3_s, WD3_s, WE3_s, RegWriteW_s, misalignedW_s} !== exp_out() || instret_s !== m_cnt[3:0]) begin
        errors++;
        $display("FAIL random_narrow_%0d: got %h cnt=%0d exp %h cnt=%0d",
                 i, {A3_s, WD3_s, WE3_s, RegWriteW_s, misalignedW_s}, instret_s, exp_out(), m_cnt[3:0]);
      end
    end
    stallW = 0; flushW = 0;
  endtask

  task automatic test_wrap();
    int n;
    drive(1, 1, 2'b00, 3'd0, 5'd1, 32'h1, 0, 0, 0);
    tick();
    n = 0;
    while (m_cnt[3:0] != 4'hF && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (instret_s !== 4'hF) begin
      errors++; $display("FAIL wrap_pre: got %0d exp 15", instret_s);
    end
    tick();
    checks++;
    if (instret_s !== 4'h0 || instret !== m_cnt) begin
      errors++; $display("FAIL wrap: got narrow=%0d wide=%0d exp narrow=0 wide=%0d",
                         instret_s, instret, m_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 2'b00, 3'd0, 5'd4, 32'hCAFE, 0, 0, 0);
    tick();
    checks++;
    if (WE3 !== 1'b1) begin
      errors++; $display("FAIL pre_reset_we: got %b exp 1", WE3);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({A3, WD3, WE3, RegWriteW, misalignedW} !== 40'h0 || instret !== 64'h0 || instret_s !== 4'h0) begin
      errors++; $display("FAIL reset_mid: got %h cnt=%0d exp 0 cnt=0",
                         {A3, WD3, WE3, RegWriteW, misalignedW}, instret);
    end
    tick();
    checks++;
    if (WE3 !== 1'b0 || instret !== 64'h0) begin
      errors++; $display("FAIL reset_hold: got WE3=%b cnt=%0d exp 0/0", WE3, instret);
    end
    #2;
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_x0_misaligned();
    test_stall_flush();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
